led_frame_writer: RTL and testbench

Parametrised successor to the zone-to-FIFO sequencer in the LED PHY path. It snapshots per-zone mean colours on `start`, then walks a parameter-defined segment map (zone index and LED count per segment). For each LED it pushes one packed colour word into the PHY TX FIFO, honouring FIFO backpressure, and pulses `send_start` once the whole frame has been written. Over the previous generation it adds a generic zone/segment count and colour width, a selectable colour order, global dimming, backpressure, abort and zero-length segments.

---
 rtl/led_phy_pkg.sv | 38 +++
 rtl/led_seg_walker.sv | 62 ++++++
 rtl/led_frame_writer.sv | 157 +++++++++++++++
 tb/tb_led_frame_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_phy_pkg.sv
// Shared types and default strip map for the LED PHY frame writer.
package led_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_SNAP,
      ST_WRITE,
      ST_DONE
   } lfw_state_t;

   localparam int unsigned CO_RGB = 0;
   localparam int unsigned CO_GRB = 1;

   localparam int unsigned DEF_ZONES = 8;
   localparam int unsigned DEF_CW    = 4;
   localparam int unsigned DEF_NSEG  = 11;
   localparam int unsigned DEF_ZW    = 3;
   localparam int unsigned DEF_LW    = 4;

   // Segment 0 sits in the LSBs and is the first segment walked:
   // zones 7,6,5,3,0,0,1,2,2,4,7 with lengths 4,4,4,4,1,4,4,4,1,4,1.
   localparam logic [DEF_NSEG*DEF_ZW-1:0] DEF_SEG_ZONE =
      {3'd7, 3'd4, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
   localparam logic [DEF_NSEG*DEF_LW-1:0] DEF_SEG_LEN =
      {4'd1, 4'd4, 4'd1, 4'd4, 4'd4, 4'd4, 4'd1, 4'd4, 4'd4, 4'd4, 4'd4};

   // Total LEDs in a default-width segment map.
   function automatic int unsigned seg_total(input logic [DEF_NSEG*DEF_LW-1:0] seg_len);
      int unsigned sum;
      sum = 0;
      for (int i = 0; i < int'(DEF_NSEG); i++) begin
         sum += 32'(seg_len[i*DEF_LW +: DEF_LW]);
      end
      return sum;
   endfunction

endpackage

// File: rtl/led_seg_walker.sv
// Walks the segment map: tracks segment/LED position and flags the frame's last step.
module led_seg_walker
   import led_phy_pkg::*;
#(
   parameter int unsigned         NSEG     = DEF_NSEG,
   parameter int unsigned         ZW       = DEF_ZW,
   parameter int unsigned         LW       = DEF_LW,
   parameter logic [NSEG*ZW-1:0]  SEG_ZONE = DEF_SEG_ZONE,
   parameter logic [NSEG*LW-1:0]  SEG_LEN  = DEF_SEG_LEN
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clear,
   input  logic          advance,
   input  logic          skip,
   output logic [ZW-1:0] zone,
   output logic          zero_len,
   output logic          last
);

   localparam int unsigned SW = (NSEG > 1) ? $clog2(NSEG) : 1;

   logic [SW-1:0] seg_idx_q;
   logic [LW-1:0] led_idx_q;
   logic [LW-1:0] len_tab  [NSEG];
   logic [ZW-1:0] zone_tab [NSEG];
   logic [LW-1:0] cur_len;
   logic          last_led;
   logic          last_seg;
   logic          seg_done;

   // Unpack the parameter map into lookup tables.
   for (genvar s = 0; s < int'(NSEG); s++) begin : g_tab
      assign len_tab[s]  = SEG_LEN[s*LW +: LW];
      assign zone_tab[s] = SEG_ZONE[s*ZW +: ZW];
   end

   assign cur_len  = len_tab[seg_idx_q];
   assign zone     = zone_tab[seg_idx_q];
   assign zero_len = (cur_len == '0);
   assign last_led = (led_idx_q == cur_len - LW'(1));
   assign last_seg = (seg_idx_q == SW'(NSEG - 1));
   assign last     = last_seg && (zero_len || last_led);
   assign seg_done = skip || (advance && last_led);

   // Position counters; hold whenever neither advance nor skip is asserted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seg_idx_q <= '0;
         led_idx_q <= '0;
      end else if (clear) begin
         seg_idx_q <= '0;
         led_idx_q <= '0;
      end else if (seg_done) begin
         led_idx_q <= '0;
         seg_idx_q <= last_seg ? '0 : seg_idx_q + SW'(1);
      end else if (advance) begin
         led_idx_q <= led_idx_q + LW'(1);
      end
   end

endmodule

// File: rtl/led_frame_writer.sv
// Snapshots per-zone colours and streams one packed word per LED into the PHY TX FIFO.
module led_frame_writer
   import led_phy_pkg::*;
#(
   parameter int unsigned         ZONES       = DEF_ZONES,
   parameter int unsigned         CW          = DEF_CW,
   parameter int unsigned         NSEG        = DEF_NSEG,
   parameter int unsigned         ZW          = DEF_ZW,
   parameter int unsigned         LW          = DEF_LW,
   parameter logic [NSEG*ZW-1:0]  SEG_ZONE    = DEF_SEG_ZONE,
   parameter logic [NSEG*LW-1:0]  SEG_LEN     = DEF_SEG_LEN,
   parameter int unsigned         COLOR_ORDER = CO_RGB
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            dim_shift,
   input  logic [ZONES*CW-1:0]   mean_r,
   input  logic [ZONES*CW-1:0]   mean_g,
   input  logic [ZONES*CW-1:0]   mean_b,
   input  logic                  fifo_full,
   output logic                  we,
   output logic [3*CW-1:0]       fifo_data,
   output logic                  send_start,
   output logic                  busy,
   output logic [15:0]           led_total
);

   lfw_state_t    state_q, state_d;
   logic [CW-1:0] snap_r_q [ZONES];
   logic [CW-1:0] snap_g_q [ZONES];
   logic [CW-1:0] snap_b_q [ZONES];
   logic [15:0]   led_cnt_q;
   logic [15:0]   led_total_q;
   logic          busy_q;
   logic          skip;
   logic          walk_clear;
   logic [ZW-1:0] zone;
   logic          zero_len;
   logic          last;
   logic [CW-1:0] ch_r, ch_g, ch_b;

   // Flag map entries that point past the zone table; those LEDs emit black.
   for (genvar s = 0; s < int'(NSEG); s++) begin : g_zchk
      if (32'(SEG_ZONE[s*ZW +: ZW]) >= ZONES) begin : g_bad
         $warning("led_frame_writer: segment %0d references out-of-range zone", s);
      end
   end

   led_seg_walker #(
      .NSEG     (NSEG),
      .ZW       (ZW),
      .LW       (LW),
      .SEG_ZONE (SEG_ZONE),
      .SEG_LEN  (SEG_LEN)
   ) u_walker (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (walk_clear),
      .advance  (we),
      .skip     (skip),
      .zone     (zone),
      .zero_len (zero_len),
      .last     (last)
   );

   assign walk_clear = (state_q == ST_SNAP);
   assign busy       = busy_q;
   assign led_total  = led_total_q;

   // Next-state and strobes; abort overrides everything outside IDLE.
   always_comb begin
      state_d    = state_q;
      we         = 1'b0;
      skip       = 1'b0;
      send_start = 1'b0;
      case (state_q)
         ST_IDLE:  if (en) state_d = ST_ARMED;
         ST_ARMED: if (start) state_d = ST_SNAP;
         ST_SNAP:  state_d = ST_WRITE;
         ST_WRITE: begin
            we   = !zero_len && !fifo_full;
            skip = zero_len;
            if (last && (we || skip)) state_d = ST_DONE;
         end
         ST_DONE: begin
            send_start = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         we         = 1'b0;
         skip       = 1'b0;
         send_start = 1'b0;
      end
   end

   // State register, busy flag and LED counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         led_cnt_q   <= '0;
         led_total_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == ST_SNAP) || (state_d == ST_WRITE) || (state_d == ST_DONE);
         if (state_q == ST_SNAP) begin
            led_cnt_q <= '0;
         end else if (we) begin
            led_cnt_q <= led_cnt_q + 16'd1;
         end
         if ((state_q == ST_DONE) && !abort) begin
            led_total_q <= led_cnt_q;
         end
      end
   end

   // Dimmed colour snapshot, frozen for the rest of the frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < int'(ZONES); k++) begin
            snap_r_q[k] <= '0;
            snap_g_q[k] <= '0;
            snap_b_q[k] <= '0;
         end
      end else if (state_q == ST_SNAP) begin
         for (int k = 0; k < int'(ZONES); k++) begin
            snap_r_q[k] <= mean_r[k*CW +: CW] >> dim_shift;
            snap_g_q[k] <= mean_g[k*CW +: CW] >> dim_shift;
            snap_b_q[k] <= mean_b[k*CW +: CW] >> dim_shift;
         end
      end
   end

   // Colour word for the current zone in the configured channel order.
   always_comb begin
      ch_r = '0;
      ch_g = '0;
      ch_b = '0;
      if (32'(zone) < ZONES) begin
         ch_r = snap_r_q[zone];
         ch_g = snap_g_q[zone];
         ch_b = snap_b_q[zone];
      end
      if (COLOR_ORDER == CO_GRB) begin
         fifo_data = {ch_g, ch_r, ch_b};
      end else begin
         fifo_data = {ch_r, ch_g, ch_b};
      end
   end

endmodule

// File: tb/tb_led_frame_writer.sv
// Randomised self-checking bench for led_frame_writer against a segment-map reference model.
module tb_led_frame_writer;
   import led_phy_pkg::*;

   localparam logic [43:0] SEG_LEN_Z =
      {4'd1, 4'd4, 4'd1, 4'd4, 4'd4, 4'd0, 4'd1, 4'd4, 4'd0, 4'd4, 4'd4};

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0, start = 1'b0, abort = 1'b0, fifo_full = 1'b0;
   logic [1:0]  dim_shift = 2'd0;
   logic [31:0] mr_a = '0, mg_a = '0, mb_a = '0;
   logic [63:0] mr_c = '0, mg_c = '0, mb_c = '0;

   logic        we_a, ss_a, busy_a;
   logic [11:0] fd_a;
   logic [15:0] tot_a;
   logic        we_c, ss_c, busy_c;
   logic [23:0] fd_c;
   logic [15:0] tot_c;
   logic        we_z, ss_z, busy_z;
   logic [11:0] fd_z;
   logic [15:0] tot_z;

   int seg_zone_m [11] = '{7, 6, 5, 3, 0, 0, 1, 2, 2, 4, 7};
   int seg_len_m  [11] = '{4, 4, 4, 4, 1, 4, 4, 4, 1, 4, 1};
   int col_r [8], col_g [8], col_b [8];
   int c8_r [8], c8_g [8], c8_b [8];

   logic [23:0] exp_q [$];
   logic [23:0] wa_d [$], wc_d [$], wz_d [$];
   int          wa_c [$], wc_c [$], wz_c [$], sa_c [$], sc_c [$], sz_c [$];
   int          cyc = 0;
   int          full_viol = 0;
   int          n_pass = 0, n_total = 0;
   int          budget;

   always #5 clk = ~clk;

   led_frame_writer dut_a (
      .clk(clk), .rstn(rstn), .en(en), .start(start), .abort(abort), .dim_shift(dim_shift),
      .mean_r(mr_a), .mean_g(mg_a), .mean_b(mb_a), .fifo_full(fifo_full),
      .we(we_a), .fifo_data(fd_a), .send_start(ss_a), .busy(busy_a), .led_total(tot_a));

   led_frame_writer #(.CW(8), .COLOR_ORDER(CO_GRB)) dut_c (
      .clk(clk), .rstn(rstn), .en(en), .start(start), .abort(abort), .dim_shift(dim_shift),
      .mean_r(mr_c), .mean_g(mg_c), .mean_b(mb_c), .fifo_full(fifo_full),
      .we(we_c), .fifo_data(fd_c), .send_start(ss_c), .busy(busy_c), .led_total(tot_c));

   led_frame_writer #(.SEG_LEN(SEG_LEN_Z)) dut_z (
      .clk(clk), .rstn(rstn), .en(en), .start(start), .abort(abort), .dim_shift(dim_shift),
      .mean_r(mr_a), .mean_g(mg_a), .mean_b(mb_a), .fifo_full(fifo_full),
      .we(we_z), .fifo_data(fd_z), .send_start(ss_z), .busy(busy_z), .led_total(tot_z));

   // Record every FIFO write and start pulse with its cycle number.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (we_a) begin wa_d.push_back(24'(fd_a)); wa_c.push_back(cyc); end
      if (we_c) begin wc_d.push_back(fd_c);      wc_c.push_back(cyc); end
      if (we_z) begin wz_d.push_back(24'(fd_z)); wz_c.push_back(cyc); end
      if (ss_a) sa_c.push_back(cyc);
      if (ss_c) sc_c.push_back(cyc);
      if (ss_z) sz_c.push_back(cyc);
      if (fifo_full && (we_a || we_c || we_z)) full_viol = full_viol + 1;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Expected word stream: walk the strip map, one dimmed colour per LED.
   function automatic void build_exp(input bit wide, input bit zsegs, input int dim);
      int len, z, r, g, b;
      exp_q.delete();
      for (int s = 0; s < 11; s++) begin
         len = (zsegs && (s == 2 || s == 5)) ? 0 : seg_len_m[s];
         z   = seg_zone_m[s];
         r   = (wide ? c8_r[z] : col_r[z]) >> dim;
         g   = (wide ? c8_g[z] : col_g[z]) >> dim;
         b   = (wide ? c8_b[z] : col_b[z]) >> dim;
         for (int j = 0; j < len; j++) begin
            exp_q.push_back(wide ? 24'((g * 65536) + (r * 256) + b) : 24'((r * 256) + (g * 16) + b));
         end
      end
   endfunction

   task automatic drive_means();
      for (int k = 0; k < 8; k++) begin
         mr_a[k*4 +: 4] = 4'(col_r[k]); mg_a[k*4 +: 4] = 4'(col_g[k]); mb_a[k*4 +: 4] = 4'(col_b[k]);
         mr_c[k*8 +: 8] = 8'(c8_r[k]);  mg_c[k*8 +: 8] = 8'(c8_g[k]);  mb_c[k*8 +: 8] = 8'(c8_b[k]);
      end
   endtask

   task automatic rand_cols();
      for (int k = 0; k < 8; k++) begin
         col_r[k] = int'($urandom_range(0, 15));  col_g[k] = int'($urandom_range(0, 15));
         col_b[k] = int'($urandom_range(0, 15));  c8_r[k]  = int'($urandom_range(0, 255));
         c8_g[k]  = int'($urandom_range(0, 255)); c8_b[k]  = int'($urandom_range(0, 255));
      end
      drive_means();
   endtask

   task automatic clear_logs();
      wa_d.delete(); wc_d.delete(); wz_d.delete();
      wa_c.delete(); wc_c.delete(); wz_c.delete();
      sa_c.delete(); sc_c.delete(); sz_c.delete();
   endtask

   // en for one cycle, then start for one cycle; returns with the DUTs in SNAP.
   task automatic kick();
      @(posedge clk); #1 en = 1'b1;
      @(posedge clk); #1 en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk); #1;
         if (!busy_a && !busy_c && !busy_z) done = 1'b1;
      end
      if (!done) begin
         n_total++;
         $display("FAIL wait_idle: busy a/c/z = %b%b%b after %0d cycles, required 000", busy_a, busy_c, busy_z, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_writes_a(input int n);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk); #1;
         if (wa_d.size() >= n) done = 1'b1;
      end
      if (!done) begin
         n_total++;
         $display("FAIL wait_writes: got %0d writes, required %0d", wa_d.size(), n);
      end
   endtask

   task automatic test_reset();
      #12;
      n_total++; if (we_a !== 1'b0)   $display("FAIL reset_we: got %b required 0", we_a);         else n_pass++;
      n_total++; if (ss_a !== 1'b0)   $display("FAIL reset_send_start: got %b required 0", ss_a); else n_pass++;
      n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy_a);     else n_pass++;
      n_total++; if (tot_a !== 16'd0) $display("FAIL reset_led_total: got %0d required 0", tot_a); else n_pass++;
      n_total++; if (fd_a !== 12'd0)  $display("FAIL reset_fifo_data: got %h required 0", fd_a);  else n_pass++;
      @(negedge clk); rstn = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (busy_a !== 1'b0) $display("FAIL idle_after_reset: busy %b required 0", busy_a); else n_pass++;
   endtask

   task automatic test_frame();
      int bad;
      for (int k = 0; k < 8; k++) begin
         col_r[k] = k; col_g[k] = k; col_b[k] = k; c8_r[k] = k; c8_g[k] = k; c8_b[k] = k;
      end
      drive_means(); dim_shift = 2'd0;
      clear_logs(); kick(); wait_idle();
      build_exp(1'b0, 1'b0, 0);
      n_total++; if (wa_d.size() != 35) $display("FAIL frame_count: got %0d writes required 35", wa_d.size()); else n_pass++;
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
      n_total++;
      if (bad >= 0) $display("FAIL frame_seq: first bad index %0d, got %0d words required %0d", bad, wa_d.size(), exp_q.size());
      else n_pass++;
      n_total++;
      if (wa_c.size() != 35 || wa_c[34] - wa_c[0] != 34)
         $display("FAIL frame_contiguous: got %0d writes spanning %0d cycles, required 35 in 35", wa_c.size(), (wa_c.size() > 0) ? wa_c[$] - wa_c[0] + 1 : 0);
      else n_pass++;
      n_total++; if (sa_c.size() != 1) $display("FAIL frame_send_count: got %0d pulses required 1", sa_c.size()); else n_pass++;
      n_total++;
      if (sa_c.size() < 1 || wa_c.size() < 1 || sa_c[0] != wa_c[$] + 1)
         $display("FAIL frame_send_timing: send at %0d, last write at %0d, required last+1", (sa_c.size() > 0) ? sa_c[0] : -1, (wa_c.size() > 0) ? wa_c[$] : -1);
      else n_pass++;
      n_total++; if (tot_a !== 16'(exp_q.size())) $display("FAIL frame_total: got %0d required %0d", tot_a, exp_q.size()); else n_pass++;
   endtask

   task automatic test_backpressure();
      int bad;
      rand_cols(); dim_shift = 2'd0; full_viol = 0;
      clear_logs(); kick();
      wait_writes_a(10);
      @(posedge clk); #1 fifo_full = 1'b1;
      repeat (5) @(posedge clk);
      #1 fifo_full = 1'b0;
      wait_writes_a(34);
      @(posedge clk); #1 fifo_full = 1'b1;
      @(posedge clk); #1 fifo_full = 1'b0;
      wait_idle();
      build_exp(1'b0, 1'b0, 0);
      n_total++; if (wa_d.size() != 35) $display("FAIL bp_count: got %0d writes required 35", wa_d.size()); else n_pass++;
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0) $display("FAIL bp_seq: first bad index %0d, got %0d words required %0d", bad, wa_d.size(), exp_q.size()); else n_pass++;
      n_total++;
      if (sa_c.size() != 1 || wa_c.size() < 1 || sa_c[0] - wa_c[0] != 41)
         $display("FAIL bp_send_timing: got %0d pulses, offset %0d, required 1 pulse at offset 41", sa_c.size(), (sa_c.size() > 0 && wa_c.size() > 0) ? sa_c[0] - wa_c[0] : -1);
      else n_pass++;
      n_total++; if (full_viol != 0) $display("FAIL bp_write_while_full: got %0d required 0", full_viol); else n_pass++;
   endtask

   task automatic test_color_order();
      int bad;
      rand_cols();
      c8_r[7] = 'hA0; c8_g[7] = 'h50; c8_b[7] = 'h0F;
      drive_means(); dim_shift = 2'd2;
      clear_logs(); kick(); wait_idle();
      n_total++;
      if (wc_d.size() < 1 || wc_d[0] !== 24'h142803)
         $display("FAIL grb_first_word: got %h required 142803", (wc_d.size() > 0) ? wc_d[0] : 24'hx);
      else n_pass++;
      build_exp(1'b1, 1'b0, 2);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wc_d.size() || wc_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0 || wc_d.size() != exp_q.size()) $display("FAIL grb_seq: first bad index %0d, got %0d words required %0d", bad, wc_d.size(), exp_q.size()); else n_pass++;
      build_exp(1'b0, 1'b0, 2);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0 || wa_d.size() != exp_q.size()) $display("FAIL dim_seq: first bad index %0d, got %0d words required %0d", bad, wa_d.size(), exp_q.size()); else n_pass++;
   endtask

   task automatic test_zero_len();
      int bad;
      int dim;
      rand_cols(); dim = int'($urandom_range(0, 3)); dim_shift = 2'(dim);
      clear_logs(); kick(); wait_idle();
      build_exp(1'b0, 1'b1, dim);
      n_total++; if (wz_d.size() != 27) $display("FAIL zl_count: got %0d writes required 27", wz_d.size()); else n_pass++;
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wz_d.size() || wz_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0 || wz_d.size() != exp_q.size()) $display("FAIL zl_seq: first bad index %0d, got %0d words required %0d", bad, wz_d.size(), exp_q.size()); else n_pass++;
      n_total++;
      if (sz_c.size() != 1 || wz_c.size() < 1 || sz_c[0] - wz_c[0] != 29)
         $display("FAIL zl_timing: got %0d pulses, offset %0d, required 1 pulse at offset 29", sz_c.size(), (sz_c.size() > 0 && wz_c.size() > 0) ? sz_c[0] - wz_c[0] : -1);
      else n_pass++;
      n_total++; if (tot_z !== 16'(exp_q.size())) $display("FAIL zl_total: got %0d required %0d", tot_z, exp_q.size()); else n_pass++;
   endtask

   task automatic test_random_frames();
      int bad;
      int dim;
      bit done;
      for (int f = 0; f < 3; f++) begin
         rand_cols(); dim = int'($urandom_range(0, 3)); dim_shift = 2'(dim); full_viol = 0;
         clear_logs(); kick();
         done = 1'b0;
         for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1 fifo_full = ($urandom_range(0, 3) == 0);
            if (!busy_a && !busy_c && !busy_z) done = 1'b1;
         end
         fifo_full = 1'b0;
         wait_idle();
         build_exp(1'b0, 1'b0, dim);
         bad = -1;
         for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
         n_total++; if (bad >= 0 || wa_d.size() != exp_q.size()) $display("FAIL rnd_seq_a[%0d]: first bad index %0d, got %0d words required %0d", f, bad, wa_d.size(), exp_q.size()); else n_pass++;
         build_exp(1'b0, 1'b1, dim);
         bad = -1;
         for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wz_d.size() || wz_d[i] !== exp_q[i])) bad = i;
         n_total++; if (bad >= 0 || wz_d.size() != exp_q.size()) $display("FAIL rnd_seq_z[%0d]: first bad index %0d, got %0d words required %0d", f, bad, wz_d.size(), exp_q.size()); else n_pass++;
         build_exp(1'b1, 1'b0, dim);
         bad = -1;
         for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wc_d.size() || wc_d[i] !== exp_q[i])) bad = i;
         n_total++; if (bad >= 0 || wc_d.size() != exp_q.size()) $display("FAIL rnd_seq_c[%0d]: first bad index %0d, got %0d words required %0d", f, bad, wc_d.size(), exp_q.size()); else n_pass++;
         n_total++; if (tot_c !== 16'(exp_q.size())) $display("FAIL rnd_total_c[%0d]: got %0d required %0d", f, tot_c, exp_q.size()); else n_pass++;
         n_total++; if (full_viol != 0) $display("FAIL rnd_write_while_full[%0d]: got %0d required 0", f, full_viol); else n_pass++;
      end
   endtask

   task automatic test_abort();
      int bad;
      logic [15:0] prev_total;
      prev_total = 16'(35);
      rand_cols(); dim_shift = 2'd0;
      clear_logs(); kick();
      wait_writes_a(11);
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      n_total++; if (we_a !== 1'b0) $display("FAIL abort_we: got %b required 0", we_a); else n_pass++;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      n_total++; if (busy_a !== 1'b0) $display("FAIL abort_idle: busy %b required 0", busy_a); else n_pass++;
      repeat (5) @(negedge clk);
      n_total++; if (wa_d.size() != 11) $display("FAIL abort_count: got %0d writes required 11", wa_d.size()); else n_pass++;
      n_total++; if (sa_c.size() != 0) $display("FAIL abort_send: got %0d pulses required 0", sa_c.size()); else n_pass++;
      n_total++; if (tot_a !== prev_total) $display("FAIL abort_total: got %0d required %0d", tot_a, prev_total); else n_pass++;
      rand_cols();
      clear_logs(); kick(); wait_idle();
      build_exp(1'b0, 1'b0, 0);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0 || wa_d.size() != exp_q.size()) $display("FAIL post_abort_seq: first bad index %0d, got %0d words required %0d", bad, wa_d.size(), exp_q.size()); else n_pass++;
      n_total++; if (tot_a !== 16'(exp_q.size())) $display("FAIL post_abort_total: got %0d required %0d", tot_a, exp_q.size()); else n_pass++;
   endtask

   task automatic test_snapshot_and_reset();
      int bad;
      int n_at_release;
      rand_cols(); dim_shift = 2'd1;
      build_exp(1'b0, 1'b0, 1);
      clear_logs(); kick();
      wait_writes_a(5);
      mr_a = ~mr_a; mg_a = mg_a ^ 32'h5A5A_5A5A; dim_shift = 2'd3;
      wait_idle();
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= wa_d.size() || wa_d[i] !== exp_q[i])) bad = i;
      n_total++; if (bad >= 0 || wa_d.size() != exp_q.size()) $display("FAIL snapshot_seq: first bad index %0d, got %0d words required %0d", bad, wa_d.size(), exp_q.size()); else n_pass++;
      clear_logs(); kick();
      wait_writes_a(8);
      @(negedge clk); #2 rstn = 1'b0;
      #1;
      n_total++; if (we_a !== 1'b0)   $display("FAIL async_rst_we: got %b required 0", we_a);         else n_pass++;
      n_total++; if (ss_a !== 1'b0)   $display("FAIL async_rst_send: got %b required 0", ss_a);      else n_pass++;
      n_total++; if (busy_a !== 1'b0) $display("FAIL async_rst_busy: got %b required 0", busy_a);    else n_pass++;
      n_total++; if (tot_a !== 16'd0) $display("FAIL async_rst_total: got %0d required 0", tot_a);   else n_pass++;
      #3 rstn = 1'b1;
      n_at_release = wa_d.size();
      repeat (6) @(negedge clk);
      n_total++; if (busy_a !== 1'b0) $display("FAIL post_rst_idle: busy %b required 0", busy_a); else n_pass++;
      n_total++; if (wa_d.size() != n_at_release) $display("FAIL post_rst_writes: got %0d required %0d", wa_d.size(), n_at_release); else n_pass++;
   endtask

   initial begin
      budget = int'(seg_total(DEF_SEG_LEN)) * 8 + 100;
      test_reset();
      test_frame();
      test_backpressure();
      test_color_order();
      test_zero_len();
      test_random_frames();
      test_abort();
      test_snapshot_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
